// File: rtl/region_job_dispatcher.sv
// Streams region records from memory to round-robin checker lanes and tallies
// the pass verdicts; finished rises once every issued region has retired.
module region_job_dispatcher #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 10,
  parameter int REC_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_regions,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [REC_W-1:0]     mem_rdata,
  input  logic [NUM_LANES-1:0] lane_idle,
  output logic [NUM_LANES-1:0] lane_start,
  output logic [REC_W-1:0]     lane_rec,
  input  logic [NUM_LANES-1:0] lane_done,
  input  logic [NUM_LANES-1:0] lane_pass,
  output logic                 busy,
  output logic                 finished,
  output logic [63:0]          result,
  output logic                 proto_err
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [ADDR_W:0]  IDX_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0] LANE_ONE = 1;

  logic [2:0]           state_q, state_d;
  logic [ADDR_W:0]      n_q, n_d;
  logic [ADDR_W:0]      issue_idx_q, issue_idx_d;
  logic [ADDR_W:0]      retired_q, retired_d;
  logic [NUM_LANES-1:0] outstanding_q, outstanding_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [REC_W-1:0]     hold_q, hold_d;
  logic [63:0]          result_q, result_d;
  logic                 proto_err_q, proto_err_d;

  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] gnt_vec;
  logic [NUM_LANES-1:0] retire_vec;
  logic [NUM_LANES-1:0] pass_vec;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     cand;
  logic                 gnt_found;
  logic                 stray;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Round-robin search starting at rr_ptr; masks use the pre-update outstanding set.
  always_comb begin
    eligible  = lane_idle & ~outstanding_q;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_LANES);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A lane launch is suppressed while reset is asserted so no job escapes an abort.
  assign gnt_vec    = (state_q == S_DISPATCH && gnt_found && rst_n) ? (LANE_ONE << gnt_idx) : '0;
  assign retire_vec = (state_q != S_IDLE) ? (lane_done & outstanding_q) : '0;
  assign pass_vec   = retire_vec & lane_pass;
  assign stray      = (state_q != S_IDLE) && (|(lane_done & ~outstanding_q));

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    issue_idx_d   = issue_idx_q;
    rr_ptr_d      = rr_ptr_q;
    hold_d        = hold_q;
    outstanding_d = (outstanding_q & ~retire_vec) | gnt_vec;
    retired_d     = retired_q + popcount(retire_vec);
    result_d      = result_q + 64'(popcount(pass_vec));
    proto_err_d   = proto_err_q | stray;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d         = num_regions;
          result_d    = '0;
          issue_idx_d = '0;
          retired_d   = '0;
          proto_err_d = 1'b0;
          state_d     = (num_regions == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        hold_d  = mem_rdata;
        state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (gnt_found) begin
          rr_ptr_d    = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_ONE;
          issue_idx_d = issue_idx_q + IDX_ONE;
          state_d     = (issue_idx_q + IDX_ONE == n_q) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (retired_q == n_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      issue_idx_q   <= '0;
      retired_q     <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      hold_q        <= '0;
      result_q      <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      issue_idx_q   <= issue_idx_d;
      retired_q     <= retired_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_q        <= hold_d;
      result_q      <= result_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign mem_rd_en  = (state_q == S_FETCH);
  assign mem_addr   = (state_q == S_FETCH) ? issue_idx_q[ADDR_W-1:0] : '0;
  assign lane_start = gnt_vec;
  assign lane_rec   = hold_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                      (state_q == S_DISPATCH) || (state_q == S_DRAIN);
  assign finished   = (state_q == S_DONE);
  assign result     = result_q;
  assign proto_err  = proto_err_q;

endmodule
